// File: rtl/sc_mul_rot_lfsr_if.sv
// Job handshake and data bus of the stochastic-computing multiplier.
// Latency: none (wires only); the owning controller drives the master side.
// Backpressure: start is only honoured while the multiplier is idle (busy=0, done=0).
//
// Port summary
//   start        job request, sampled on the rising edge of clk
//   mode         0 = unipolar (AND), 1 = bipolar (XNOR)
//   iA, iB       operands, WIDTH bits
//   iseedA/B     LFSR seeds, WIDTH bits (0 is treated as 1)
//   ilen         stream length in cycles, 2*WIDTH bits
//   busy         high while the stream is being sampled
//   done         one-cycle completion pulse
//   oC           ones count, valid from done until the next accepted start
interface sc_mul_rot_lfsr_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 mode;
    logic [WIDTH-1:0]     iA;
    logic [WIDTH-1:0]     iB;
    logic [WIDTH-1:0]     iseedA;
    logic [WIDTH-1:0]     iseedB;
    logic [2*WIDTH-1:0]   ilen;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   oC;

    // Controller side: issues jobs and collects results.
    modport master (
        output start,
        output mode,
        output iA,
        output iB,
        output iseedA,
        output iseedB,
        output ilen,
        input  busy,
        input  done,
        input  oC
    );

    // Multiplier side.
    modport slave (
        input  start,
        input  mode,
        input  iA,
        input  iB,
        input  iseedA,
        input  iseedB,
        input  ilen,
        output busy,
        output done,
        output oC
    );
endinterface

// File: rtl/sc_mul_rot_lfsr.sv
// Stochastic multiplier: two LFSR-driven bitstreams, AND/XNOR combined, ones counted.
// Latency: accepted start -> ilen sampling cycles -> one-cycle done pulse (ilen+1 cycles).
// Backpressure: start is accepted only in IDLE; requests while busy or in DONE are dropped.
//
// Ports
//   clk   rising-edge clock for all state
//   rst   synchronous active-high reset; aborts any running job
//   bus   slave side of sc_mul_rot_lfsr_if (start/mode/operands/seeds/ilen in,
//         busy/done/oC out)
//
// LFSR B holds for one cycle at the end of every LFSR A period, so over
// (2^WIDTH-1)^2 cycles the pair (lfsrA, lfsrB) walks every combination of
// non-zero states exactly once.
module sc_mul_rot_lfsr #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    sc_mul_rot_lfsr_if.slave  bus
);

    // Feedback taps for a maximal-length Fibonacci LFSR of each legal width,
    // written as a 12-bit mask and trimmed to WIDTH.
    localparam logic [11:0] TAPS12 =
        (WIDTH == 4)  ? 12'h00C :   // 3,2
        (WIDTH == 5)  ? 12'h014 :   // 4,2
        (WIDTH == 6)  ? 12'h030 :   // 5,4
        (WIDTH == 7)  ? 12'h060 :   // 6,5
        (WIDTH == 8)  ? 12'h0B8 :   // 7,5,4,3
        (WIDTH == 9)  ? 12'h110 :   // 8,4
        (WIDTH == 10) ? 12'h240 :   // 9,6
        (WIDTH == 11) ? 12'h500 :   // 10,8
                        12'hE08;    // 12: 11,10,9,3
    localparam logic [WIDTH-1:0] TAPS = TAPS12[WIDTH-1:0];

    // Last value of the A-period counter (2^WIDTH - 2); B holds in that cycle.
    localparam logic [WIDTH-1:0] PCNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;

    // Job parameters captured at start.
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               mode_q;
    logic [2*WIDTH-1:0] len_q;

    // Stream generators and counters.
    logic [WIDTH-1:0]   lfsr_a;
    logic [WIDTH-1:0]   lfsr_b;
    logic [WIDTH-1:0]   pcnt;
    logic [2*WIDTH-1:0] cyc;
    logic [2*WIDTH-1:0] oc_q;

    // Registered handshake outputs.
    logic               busy_q;
    logic               done_q;

    // Combinational per-sample terms.
    logic               bit_a;
    logic               bit_b;
    logic               hit;
    logic [2*WIDTH-1:0] hit_ext;
    logic               pcnt_last;
    logic               last_sample;
    logic [WIDTH-1:0]   seed_a_fix;
    logic [WIDTH-1:0]   seed_b_fix;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    // The all-zero state would lock the LFSR, so a zero seed becomes 1.
    assign seed_a_fix = (bus.iseedA == '0) ? ONE_W : bus.iseedA;
    assign seed_b_fix = (bus.iseedB == '0) ? ONE_W : bus.iseedB;

    // Operand-to-bit conversion: P(bit=1) = operand / 2^WIDTH over a period.
    assign bit_a   = (a_q > lfsr_a);
    assign bit_b   = (b_q > lfsr_b);
    assign hit     = mode_q ? ~(bit_a ^ bit_b) : (bit_a & bit_b);
    assign hit_ext = {{(2*WIDTH-1){1'b0}}, hit};

    assign pcnt_last   = (pcnt == PCNT_LAST);
    // Only evaluated in RUN, where len_q is known to be non-zero.
    assign last_sample = (cyc == (len_q - ONE_2W));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            len_q  <= '0;
            lfsr_a <= '0;
            lfsr_b <= '0;
            pcnt   <= '0;
            cyc    <= '0;
            oc_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.iA;
                        b_q    <= bus.iB;
                        mode_q <= bus.mode;
                        len_q  <= bus.ilen;
                        lfsr_a <= seed_a_fix;
                        lfsr_b <= seed_b_fix;
                        pcnt   <= '0;
                        cyc    <= '0;
                        oc_q   <= '0;
                        // A zero-length job skips sampling and reports oC=0 at once.
                        if (bus.ilen != '0) begin
                            state  <= S_RUN;
                            busy_q <= 1'b1;
                        end else begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    oc_q   <= oc_q + hit_ext;
                    lfsr_a <= lfsr_step(lfsr_a);
                    // Holding B once per A period rotates the pairing each period.
                    if (!pcnt_last) begin
                        lfsr_b <= lfsr_step(lfsr_b);
                    end
                    pcnt <= pcnt_last ? '0 : (pcnt + ONE_W);
                    cyc  <= cyc + ONE_2W;
                    if (last_sample) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end

                S_DONE: begin
                    // oC is left untouched so it stays readable until the next job.
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                end

                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.oC   = oc_q;

endmodule

// File: tb/tb_sc_mul_rot_lfsr.sv
module tb_sc_mul_rot_lfsr;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sc_mul_rot_lfsr_if #(.WIDTH(4))  if4();
    sc_mul_rot_lfsr_if #(.WIDTH(8))  if8();
    sc_mul_rot_lfsr_if #(.WIDTH(12)) if12();

    sc_mul_rot_lfsr #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
    sc_mul_rot_lfsr #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
    sc_mul_rot_lfsr #(.WIDTH(12)) dut12 (.clk(clk), .rst(rst), .bus(if12));

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int tap_mask(input int w);
        case (w)
            4:  return (1 << 3) | (1 << 2);
            5:  return (1 << 4) | (1 << 2);
            6:  return (1 << 5) | (1 << 4);
            7:  return (1 << 6) | (1 << 5);
            8:  return (1 << 7) | (1 << 5) | (1 << 4) | (1 << 3);
            9:  return (1 << 8) | (1 << 4);
            10: return (1 << 9) | (1 << 6);
            11: return (1 << 10) | (1 << 8);
            default: return (1 << 11) | (1 << 10) | (1 << 9) | (1 << 3);
        endcase
    endfunction

    function automatic int lfsr_next(input int s, input int w);
        int fb;
        fb = $countones(s & tap_mask(w)) & 1;
        return ((s << 1) | fb) & ((1 << w) - 1);
    endfunction

    // Count of ones over len samples; B is held once every (2^w-1) samples.
    function automatic int model(input int w, input int mode, input int a, input int b,
                                 input int sa, input int sb, input int len);
        int period, va, vb, cnt;
        bit ba, bb;
        period = (1 << w) - 1;
        va  = (sa == 0) ? 1 : sa;
        vb  = (sb == 0) ? 1 : sb;
        cnt = 0;
        for (int k = 0; k < len; k++) begin
            ba = (a > va);
            bb = (b > vb);
            if (mode != 0) cnt += (ba == bb) ? 1 : 0;
            else           cnt += (ba && bb) ? 1 : 0;
            va = lfsr_next(va, w);
            if ((k % period) != period - 1) vb = lfsr_next(vb, w);
        end
        return cnt;
    endfunction

    // ---------------- DUT access helpers ----------------
    task automatic drive(input int w, input bit s, input int mode, input int a, input int b,
                         input int sa, input int sb, input int len);
        case (w)
            4: begin
                if4.start = s; if4.mode = mode[0]; if4.iA = a[3:0]; if4.iB = b[3:0];
                if4.iseedA = sa[3:0]; if4.iseedB = sb[3:0]; if4.ilen = len[7:0];
            end
            8: begin
                if8.start = s; if8.mode = mode[0]; if8.iA = a[7:0]; if8.iB = b[7:0];
                if8.iseedA = sa[7:0]; if8.iseedB = sb[7:0]; if8.ilen = len[15:0];
            end
            default: begin
                if12.start = s; if12.mode = mode[0]; if12.iA = a[11:0]; if12.iB = b[11:0];
                if12.iseedA = sa[11:0]; if12.iseedB = sb[11:0]; if12.ilen = len[23:0];
            end
        endcase
    endtask

    task automatic drive_junk(input int w, input bit s);
        drive(w, s, int'($urandom), int'($urandom), int'($urandom),
              int'($urandom), int'($urandom), int'($urandom));
    endtask

    function automatic bit get_busy(input int w);
        case (w)
            4:       return if4.busy;
            8:       return if8.busy;
            default: return if12.busy;
        endcase
    endfunction

    function automatic bit get_done(input int w);
        case (w)
            4:       return if4.done;
            8:       return if8.done;
            default: return if12.done;
        endcase
    endfunction

    function automatic int get_oc(input int w);
        case (w)
            4:       return int'(if4.oC);
            8:       return int'(if8.oC);
            default: return int'(if12.oC);
        endcase
    endfunction

    // Issue one job at the next falling edge and wait (bounded) for done.
    // lat counts cycles from the start cycle to the done cycle.
    task automatic run_job(input int w, input int mode, input int a, input int b,
                           input int sa, input int sb, input int len, input bit pulses,
                           output int oc, output int lat, output int bcnt);
        @(negedge clk);
        drive(w, 1'b1, mode, a, b, sa, sb, len);
        @(negedge clk);
        drive_junk(w, 1'b0);
        lat  = 1;
        bcnt = 0;
        while (!get_done(w) && lat < len + 10) begin
            if (get_busy(w)) bcnt++;
            // Extra start requests with scrambled operands while running.
            if (pulses && get_busy(w) && (lat % 5 == 2)) drive_junk(w, 1'b1);
            else                                         drive_junk(w, 1'b0);
            @(negedge clk);
            lat++;
        end
        drive_junk(w, 1'b0);
        chk($sformatf("w%0d_done_seen", w), get_done(w), 1);
        chk($sformatf("w%0d_busy_low_at_done", w), get_busy(w), 0);
        oc = get_oc(w);
    endtask

    typedef struct {
        int mode, a, b, sa, sb, len;
        int exp_oc, exp_lat, exp_busy;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int oc, lat, bc;

        tbl[0] = '{0, 200, 0,   'h11, 'h22, 1000, 0,   1001, 1000}; // unipolar zero
        tbl[1] = '{1, 128, 0,   'h5A, 'hC3, 255,  128, 256,  255};  // bipolar one period
        tbl[2] = '{1, 128, 0,   0,    'hC3, 255,  128, 256,  255};  // zero seed -> 1
        tbl[3] = '{0, 255, 255, 3,    4,    0,    0,   1,    0};    // ilen = 0
        tbl[4] = '{1, 0,   0,   7,    9,    77,   77,  78,   77};   // all samples agree
        tbl[5] = '{1, 0,   255, 'h80, 'h01, 255,  1,   256,  255};  // B bit low only at 255
        tbl[6] = '{0, 0,   200, 'h33, 0,    40,   0,   41,   40};   // iA=0 -> no ones

        // ---- reset held with start asserted ----
        rst = 1'b1;
        drive(4, 1'b1, 0, 5, 5, 1, 1, 10);
        drive(8, 1'b1, 1, 50, 60, 1, 2, 10);
        drive(12, 1'b1, 0, 5, 5, 1, 1, 10);
        repeat (3) @(negedge clk);
        chk("rst_busy", if8.busy, 0);
        chk("rst_done", if8.done, 0);
        chk("rst_oc", if8.oC, 0);
        chk("rst_busy_w4", if4.busy, 0);
        chk("rst_busy_w12", if12.busy, 0);
        rst = 1'b0;
        drive_junk(4, 1'b0);
        drive_junk(12, 1'b0);
        // start still high on the first edge after rst falls: job now accepted
        @(negedge clk);
        chk("post_rst_start_accepted", if8.busy, 1);
        drive_junk(8, 1'b0);
        repeat (15) @(negedge clk);
        chk("post_rst_job_idle", if8.busy, 0);

        // ---- table-driven vectors, issued back to back ----
        for (int i = 0; i < 7; i++) begin
            run_job(8, tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].sa, tbl[i].sb, tbl[i].len,
                    1'b0, oc, lat, bc);
            chk($sformatf("vec%0d_oc", i), oc, tbl[i].exp_oc);
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("vec%0d_busy_cycles", i), bc, tbl[i].exp_busy);
        end

        // ---- start pulses during RUN are ignored ----
        run_job(8, 1, 128, 0, 'h5A, 'hC3, 255, 1'b1, oc, lat, bc);
        chk("pulses_oc", oc, 128);
        chk("pulses_latency", lat, 256);
        @(negedge clk);
        chk("oc_held_after_done", if8.oC, 128);
        chk("idle_after_done", if8.done, 0);

        // ---- back-to-back start clears oC ----
        run_job(8, 0, 0, 0, 1, 1, 5, 1'b0, oc, lat, bc);
        chk("b2b_cleared_oc", oc, 0);
        chk("b2b_latency", lat, 6);

        // ---- reset mid-run, then rerun ----
        @(negedge clk);
        drive(8, 1'b1, 1, 128, 0, 'h5A, 'hC3, 255);
        @(negedge clk);
        drive_junk(8, 1'b0);
        repeat (99) @(negedge clk);
        chk("midrun_busy_before_rst", if8.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_rst_busy", if8.busy, 0);
        chk("midrun_rst_done", if8.done, 0);
        chk("midrun_rst_oc", if8.oC, 0);
        @(negedge clk);
        chk("midrun_rst_stays_idle", if8.busy, 0);
        run_job(8, 1, 128, 0, 'h5A, 'hC3, 255, 1'b0, oc, lat, bc);
        chk("rerun_oc", oc, 128);

        // ---- long jobs and randomized jobs in parallel on the three widths ----
        fork
            begin
                int oc8, lat8, bc8;
                run_job(8, 1, 128, 128, 'h37, 'h91, 65025, 1'b0, oc8, lat8, bc8);
                chk("full_rot_w8_xnor_oc", oc8, 32513);
                chk("full_rot_w8_latency", lat8, 65026);
            end
            begin
                int oc4, lat4, bc4, m, a, b, sa, sb, len;
                run_job(4, 0, 8, 8, 5, 9, 225, 1'b0, oc4, lat4, bc4);
                chk("full_rot_w4_and_oc", oc4, 49);
                run_job(4, 1, 8, 8, 0, 3, 225, 1'b0, oc4, lat4, bc4);
                chk("full_rot_w4_xnor_oc", oc4, 113);
                for (int j = 0; j < 25; j++) begin
                    m   = int'($urandom_range(0, 1));
                    a   = int'($urandom_range(0, 15));
                    b   = int'($urandom_range(0, 15));
                    sa  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
                    sb  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
                    len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
                    run_job(4, m, a, b, sa, sb, len, 1'(j % 2), oc4, lat4, bc4);
                    chk($sformatf("rand_w4_%0d_oc", j), oc4, model(4, m, a, b, sa, sb, len));
                    chk($sformatf("rand_w4_%0d_latency", j), lat4, len + 1);
                end
            end
            begin
                int oc12, lat12, bc12, m, a, b, sa, sb, len;
                for (int j = 0; j < 12; j++) begin
                    m   = int'($urandom_range(0, 1));
                    a   = int'($urandom_range(0, 4095));
                    b   = int'($urandom_range(0, 4095));
                    sa  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 4095));
                    sb  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 4095));
                    len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5000));
                    run_job(12, m, a, b, sa, sb, len, 1'b0, oc12, lat12, bc12);
                    chk($sformatf("rand_w12_%0d_oc", j), oc12, model(12, m, a, b, sa, sb, len));
                    chk($sformatf("rand_w12_%0d_latency", j), lat12, len + 1);
                end
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    // Safety net in case the run never reaches its summary.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d",
                 n_checks, n_err);
        $fatal(1, "watchdog");
    end

endmodule
